// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller: FSM encodings,
// register-index width and the RAW compare helper.
package pipe_hazard_ctrl_pkg;

    localparam int REG_IDX_W = 4;

    localparam logic [0:0] HZ_RUN      = 1'b0;
    localparam logic [0:0] HZ_MEM_WAIT = 1'b1;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    typedef struct packed {
        logic freeze_pc;
        logic freeze_if_id;
        logic flush_if_id;
        logic freeze_id_ex;
        logic flush_id_ex;
        logic freeze_exe_mem;
        logic flush_mem_wb;
    } hz_ctrl_t;

    // R0 is a real register, so index 0 is compared like any other.
    function automatic logic raw_match(input logic     wb_en,
                                       input reg_idx_t dest,
                                       input reg_idx_t src1,
                                       input logic     use1,
                                       input reg_idx_t src2,
                                       input logic     use2);
        return wb_en & ((use1 & (src1 == dest)) | (use2 & (src2 == dest)));
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle of pipeline status inputs and stall/flush outputs of the hazard controller.
interface pipe_hazard_ctrl_if #(parameter int CNT_W = 16);
    import pipe_hazard_ctrl_pkg::*;

    reg_idx_t         id_src1;
    reg_idx_t         id_src2;
    logic             id_use_src1;
    logic             id_use_src2;
    reg_idx_t         exe_dest;
    logic             exe_wb_en;
    logic             exe_mem_read;
    reg_idx_t         mem_dest;
    logic             mem_wb_en;
    logic             fwd_en;
    logic             exe_branch;
    logic             mem_req;
    logic             mem_ready;

    logic             freeze_pc;
    logic             freeze_if_id;
    logic             flush_if_id;
    logic             freeze_id_ex;
    logic             flush_id_ex;
    logic             freeze_exe_mem;
    logic             flush_mem_wb;
    logic             mem_timeout;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output id_src1, id_src2, id_use_src1, id_use_src2,
               exe_dest, exe_wb_en, exe_mem_read, mem_dest, mem_wb_en,
               fwd_en, exe_branch, mem_req, mem_ready,
        input  freeze_pc, freeze_if_id, flush_if_id, freeze_id_ex, flush_id_ex,
               freeze_exe_mem, flush_mem_wb, mem_timeout, mem_err, stall_cycles
    );

    modport slave (
        input  id_src1, id_src2, id_use_src1, id_use_src2,
               exe_dest, exe_wb_en, exe_mem_read, mem_dest, mem_wb_en,
               fwd_en, exe_branch, mem_req, mem_ready,
        output freeze_pc, freeze_if_id, flush_if_id, freeze_id_ex, flush_id_ex,
               freeze_exe_mem, flush_mem_wb, mem_timeout, mem_err, stall_cycles
    );

endinterface

// File: rtl/pipe_hazard_ctrl_mem_wait_fsm.sv
// Tracks a multi-cycle SRAM access in MEM and abandons it after MEM_TIMEOUT cycles.
//  state       | meaning
//  HZ_RUN      | no access pending beyond the current cycle
//  HZ_MEM_WAIT | access outstanding, wait_cnt counts cycles already stalled
module pipe_hazard_ctrl_mem_wait_fsm
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic mem_req_i,
    input  logic mem_ready_i,
    output logic abandon_o,
    output logic mem_timeout_o,
    output logic mem_err_o
);

    localparam int              WC_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WC_W-1:0] LAST = WC_W'(MEM_TIMEOUT - 1);

    logic [0:0]      state_q, state_d;
    logic [WC_W-1:0] wait_cnt_q, wait_cnt_d;
    logic            mem_err_q, mem_err_d;
    logic            abandon;
    logic            timeout;

    assign abandon = (state_q == HZ_MEM_WAIT) && (wait_cnt_q == LAST);

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        timeout    = 1'b0;
        case (state_q)
            HZ_RUN: begin
                if (mem_req_i && !mem_ready_i) begin
                    state_d    = HZ_MEM_WAIT;
                    wait_cnt_d = WC_W'(1);
                end
            end
            HZ_MEM_WAIT: begin
                // A dropped request is treated as spurious and leaves no error behind.
                if (mem_ready_i || !mem_req_i) begin
                    state_d    = HZ_RUN;
                    wait_cnt_d = '0;
                end else if (abandon) begin
                    state_d    = HZ_RUN;
                    wait_cnt_d = '0;
                    timeout    = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WC_W'(1);
                end
            end
            default: begin
                state_d    = HZ_RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    assign mem_err_d = mem_err_q | timeout;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= HZ_RUN;
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
        end
    end

    assign abandon_o     = abandon;
    assign mem_timeout_o = timeout & ~rst;
    assign mem_err_o     = mem_err_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: RAW hazard detect, branch flush,
// SRAM wait stall and a saturating stall-cycle counter.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic               clk,
    input  logic               rst,
    pipe_hazard_ctrl_if.slave  bus
);

    logic             raw_exe;
    logic             raw_mem;
    logic             data_hz;
    logic             abandon;
    logic             mem_stall;
    logic             mem_timeout;
    logic             mem_err;
    hz_ctrl_t         ctrl;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

    pipe_hazard_ctrl_mem_wait_fsm #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_mem_wait_fsm (
        .clk           (clk),
        .rst           (rst),
        .mem_req_i     (bus.mem_req),
        .mem_ready_i   (bus.mem_ready),
        .abandon_o     (abandon),
        .mem_timeout_o (mem_timeout),
        .mem_err_o     (mem_err)
    );

    assign raw_exe = raw_match(bus.exe_wb_en, bus.exe_dest, bus.id_src1, bus.id_use_src1,
                               bus.id_src2, bus.id_use_src2);
    assign raw_mem = raw_match(bus.mem_wb_en, bus.mem_dest, bus.id_src1, bus.id_use_src1,
                               bus.id_src2, bus.id_use_src2);

    // With forwarding only a load in EXE cannot be bypassed in time.
    assign data_hz   = bus.fwd_en ? (raw_exe & bus.exe_mem_read) : (raw_exe | raw_mem);
    assign mem_stall = bus.mem_req & ~bus.mem_ready & ~abandon;

    always_comb begin
        ctrl = '0;
        if (!rst) begin
            if (mem_stall) begin
                ctrl.freeze_pc      = 1'b1;
                ctrl.freeze_if_id   = 1'b1;
                ctrl.freeze_id_ex   = 1'b1;
                ctrl.freeze_exe_mem = 1'b1;
                ctrl.flush_mem_wb   = 1'b1;
            end else if (bus.exe_branch) begin
                ctrl.flush_if_id    = 1'b1;
                ctrl.flush_id_ex    = 1'b1;
            end else if (data_hz) begin
                ctrl.freeze_pc      = 1'b1;
                ctrl.freeze_if_id   = 1'b1;
                ctrl.flush_id_ex    = 1'b1;
            end
        end
    end

    assign stall_cycles_d = (ctrl.freeze_pc && (stall_cycles_q != '1))
                          ? stall_cycles_q + CNT_W'(1) : stall_cycles_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign bus.freeze_pc      = ctrl.freeze_pc;
    assign bus.freeze_if_id   = ctrl.freeze_if_id;
    assign bus.flush_if_id    = ctrl.flush_if_id;
    assign bus.freeze_id_ex   = ctrl.freeze_id_ex;
    assign bus.flush_id_ex    = ctrl.flush_id_ex;
    assign bus.freeze_exe_mem = ctrl.freeze_exe_mem;
    assign bus.flush_mem_wb   = ctrl.flush_mem_wb;
    assign bus.mem_timeout    = mem_timeout;
    assign bus.mem_err        = mem_err;
    assign bus.stall_cycles   = stall_cycles_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed scenarios then random traffic,
// checked against a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;

    localparam int MT = 4;
    localparam int CW = 8;

    typedef struct packed {
        logic       rst;
        logic [3:0] src1;
        logic [3:0] src2;
        logic       use1;
        logic       use2;
        logic [3:0] exe_dest;
        logic       exe_wb;
        logic       exe_rd;
        logic [3:0] mem_dest;
        logic       mem_wb;
        logic       fwd;
        logic       br;
        logic       req;
        logic       ready;
    } stim_t;

    typedef struct packed {
        logic [7:0]    ctrl;   // fpc,fifid,flifid,fidex,flidex,fexm,flmw,mto
        logic          merr;
        logic [CW-1:0] sc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.CNT_W(CW)) bus();

    pipe_hazard_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    int   m_age = 0;
    bit   m_err = 1'b0;
    int   m_sc  = 0;

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        return s;
    endfunction

    function automatic bit raw(input logic [3:0] d, input logic wb, input stim_t s);
        return wb && ((s.use1 && s.src1 == d) || (s.use2 && s.src2 == d));
    endfunction

    task automatic model(input stim_t s, output exp_t e);
        bit dhz, unready, abandon;
        e      = '0;
        e.merr = m_err;
        e.sc   = m_sc[CW-1:0];
        if (s.rst) begin
            m_age = 0;
            m_err = 1'b0;
            m_sc  = 0;
            return;
        end
        dhz = s.fwd ? (raw(s.exe_dest, s.exe_wb, s) && s.exe_rd)
                    : (raw(s.exe_dest, s.exe_wb, s) || raw(s.mem_dest, s.mem_wb, s));
        unready = s.req && !s.ready;
        abandon = unready && (m_age == MT - 1);
        if (unready && !abandon) begin
            e.ctrl = 8'b1101_0110;
            m_age++;
        end else begin
            m_age = 0;
            if (abandon) begin
                e.ctrl[0] = 1'b1;
                m_err     = 1'b1;
            end
            if (s.br)     e.ctrl[7:1] = 7'b0010_100;
            else if (dhz) e.ctrl[7:1] = 7'b1100_100;
        end
        if (e.ctrl[7] && m_sc < (1 << CW) - 1) m_sc++;
    endtask

    task automatic go(input stim_t s);
        exp_t e;
        @(posedge clk);
        #1;
        rst              = s.rst;
        bus.id_src1      = s.src1;
        bus.id_src2      = s.src2;
        bus.id_use_src1  = s.use1;
        bus.id_use_src2  = s.use2;
        bus.exe_dest     = s.exe_dest;
        bus.exe_wb_en    = s.exe_wb;
        bus.exe_mem_read = s.exe_rd;
        bus.mem_dest     = s.mem_dest;
        bus.mem_wb_en    = s.mem_wb;
        bus.fwd_en       = s.fwd;
        bus.exe_branch   = s.br;
        bus.mem_req      = s.req;
        bus.mem_ready    = s.ready;
        model(s, e);
        q.push_back(e);
    endtask

    task automatic go_n(input stim_t s, input int n);
        for (int i = 0; i < n; i++) go(s);
    endtask

    initial begin : monitor
        exp_t       e;
        logic [7:0] act;
        forever begin
            @(negedge clk);
            cyc++;
            if (q.size() > 0) begin
                e   = q.pop_front();
                act = {bus.freeze_pc, bus.freeze_if_id, bus.flush_if_id, bus.freeze_id_ex,
                       bus.flush_id_ex, bus.freeze_exe_mem, bus.flush_mem_wb, bus.mem_timeout};
                n_chk++;
                if (act !== e.ctrl) begin
                    n_fail++;
                    $display("FAIL ctrl cyc=%0d actual=%b expected=%b", cyc, act, e.ctrl);
                end
                n_chk++;
                if (bus.mem_err !== e.merr) begin
                    n_fail++;
                    $display("FAIL mem_err cyc=%0d actual=%b expected=%b", cyc, bus.mem_err, e.merr);
                end
                n_chk++;
                if (bus.stall_cycles !== e.sc) begin
                    n_fail++;
                    $display("FAIL stall_cycles cyc=%0d actual=%0d expected=%0d",
                             cyc, bus.stall_cycles, e.sc);
                end
            end
        end
    end

    initial begin : stimulus
        stim_t s, r;
        rst = 1'b1;
        s = idle();
        bus.id_src1 = '0; bus.id_src2 = '0; bus.id_use_src1 = 0; bus.id_use_src2 = 0;
        bus.exe_dest = '0; bus.exe_wb_en = 0; bus.exe_mem_read = 0; bus.mem_dest = '0;
        bus.mem_wb_en = 0; bus.fwd_en = 0; bus.exe_branch = 0; bus.mem_req = 0; bus.mem_ready = 0;
        r = idle(); r.rst = 1'b1;
        go_n(r, 2);
        go(idle());

        // RAW on EXE without forwarding, then dest moves away
        s = idle(); s.src1 = 4'd3; s.use1 = 1; s.exe_dest = 4'd3; s.exe_wb = 1;
        go(s);
        s.exe_dest = 4'd5; go(s);
        // forwarding: ALU result bypassed, load stalls
        s.exe_dest = 4'd3; s.fwd = 1; s.exe_rd = 0; go(s);
        s.exe_rd = 1; go(s);
        // R0 compared as real register on MEM path
        s = idle(); s.src2 = 4'd0; s.use2 = 1; s.mem_dest = 4'd0; s.mem_wb = 1; go(s);
        // branch beats data hazard
        s = idle(); s.src1 = 4'd3; s.use1 = 1; s.exe_dest = 4'd3; s.exe_wb = 1; s.br = 1;
        go(s);

        // three wait cycles then ready, counter from reset
        go(r);
        s = idle(); s.req = 1; s.br = 1; s.src1 = 4'd2; s.use1 = 1; s.exe_dest = 4'd2; s.exe_wb = 1;
        go_n(s, 3);
        s.ready = 1; go(s);
        go_n(idle(), 2);

        // timeout with request held, then sticky error
        go(r);
        s = idle(); s.req = 1;
        go_n(s, 6);
        go_n(idle(), 3);
        // spurious drop of request mid-wait: no error
        go(r);
        go_n(s, 2); go(idle());
        s.ready = 1; go(s);
        go_n(idle(), 2);

        // saturate the counter via a held data hazard, then reset mid-wait
        s = idle(); s.src1 = 4'd7; s.use1 = 1; s.mem_dest = 4'd7; s.mem_wb = 1;
        go_n(s, 300);
        s = idle(); s.req = 1;
        go_n(s, 3);
        r.req = 1; go(r); r.req = 0;
        go_n(s, 2);
        go_n(idle(), 2);

        for (int i = 0; i < 3000; i++) begin
            s          = idle();
            s.rst      = ($urandom_range(0, 99) == 0);
            s.src1     = 4'($urandom_range(0, 3));
            s.src2     = 4'($urandom_range(0, 3));
            s.use1     = ($urandom_range(0, 1) == 1);
            s.use2     = ($urandom_range(0, 1) == 1);
            s.exe_dest = 4'($urandom_range(0, 3));
            s.exe_wb   = ($urandom_range(0, 9) < 7);
            s.exe_rd   = ($urandom_range(0, 9) < 3);
            s.mem_dest = 4'($urandom_range(0, 3));
            s.mem_wb   = ($urandom_range(0, 9) < 7);
            s.fwd      = ($urandom_range(0, 1) == 1);
            s.br       = ($urandom_range(0, 99) < 15);
            s.req      = ($urandom_range(0, 9) < 5);
            s.ready    = ($urandom_range(0, 9) < 3);
            go(s);
        end

        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain actual=%0d pending expected=0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
